// File: rtl/vote_result_display.sv
// Election result stage: snapshots four vote totals, finds the winner sequentially,
// converts the winning count to BCD and scans it onto a 4-digit seven-segment display.
module vote_result_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic       show,
  input  logic [7:0] cand1_vote,
  input  logic [7:0] cand2_vote,
  input  logic [7:0] cand3_vote,
  input  logic [7:0] cand4_vote,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       busy,
  output logic       done,
  output logic       tie
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, COMPARE, CONVERT, DISPLAY} state_t;

  state_t           state, state_nx;
  logic             accept;
  logic [1:0]       idx_p0;
  logic [2:0]       conv_cnt_p1;
  logic             tie_r;
  logic [7:0]       snap_p0 [4];
  logic [7:0]       max_p0;
  logic [2:0]       winner_p0;
  logic [9:0]       bcd_p1;
  logic [CNT_W-1:0] ref_cnt_p2;
  logic [1:0]       sel_p2;
  logic [3:0]       digit_val;
  logic             digit_blank;

  function automatic logic [9:0] bcd_adjust(input logic [9:0] b);
    logic [9:0] r;
    r = b;
    if (r[3:0] >= 4'd5) r[3:0] = r[3:0] + 4'd3;
    if (r[7:4] >= 4'd5) r[7:4] = r[7:4] + 4'd3;
    return r;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE, DISPLAY: if (show) begin
        accept   = 1'b1;
        state_nx = COMPARE;
      end
      COMPARE: if (idx_p0 == 2'd3) state_nx = CONVERT;
      CONVERT: if (conv_cnt_p1 == 3'd7) state_nx = DISPLAY;
      default: state_nx = IDLE;
    endcase
    // Dropping out of result mode overrides everything, including a new request.
    if (!mode) begin
      state_nx = IDLE;
      accept   = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  assign busy = (state == COMPARE) || (state == CONVERT);
  assign tie  = tie_r && (state == DISPLAY);

  // Stage p0: snapshot and sequential maximum search
  always_ff @(posedge clock) begin
    if (accept) begin
      snap_p0[0] <= cand1_vote;
      snap_p0[1] <= cand2_vote;
      snap_p0[2] <= cand3_vote;
      snap_p0[3] <= cand4_vote;
      max_p0     <= 8'd0;
      winner_p0  <= 3'd1;
      bcd_p1     <= 10'd0;
    end else if (state == COMPARE) begin
      if (snap_p0[idx_p0] > max_p0) begin
        max_p0    <= snap_p0[idx_p0];
        winner_p0 <= {1'b0, idx_p0} + 3'd1;
      end
    // Stage p1: double-dabble, max_p0 doubles as the binary shift source
    end else if (state == CONVERT) begin
      {bcd_p1, max_p0} <= {bcd_adjust(bcd_p1), max_p0} << 1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_p0      <= 2'd0;
      conv_cnt_p1 <= 3'd0;
      tie_r       <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= (state == CONVERT) && (state_nx == DISPLAY);
      if (accept) begin
        idx_p0      <= 2'd0;
        conv_cnt_p1 <= 3'd0;
        tie_r       <= 1'b0;
      end else if (!mode) begin
        tie_r <= 1'b0;
      end else if (state == COMPARE) begin
        idx_p0 <= idx_p0 + 2'd1;
        if (snap_p0[idx_p0] > max_p0)       tie_r <= 1'b0;
        else if (snap_p0[idx_p0] == max_p0) tie_r <= 1'b1;
      end else if (state == CONVERT) begin
        conv_cnt_p1 <= conv_cnt_p1 + 3'd1;
      end
    end
  end

  // Stage p2: digit selection and multiplexed scan
  always_comb begin
    digit_val   = bcd_p1[3:0];
    digit_blank = 1'b0;
    case (sel_p2)
      2'd0: digit_val = bcd_p1[3:0];
      2'd1: begin
        digit_val   = bcd_p1[7:4];
        digit_blank = (bcd_p1[9:8] == 2'd0) && (bcd_p1[7:4] == 4'd0);
      end
      2'd2: begin
        digit_val   = {2'b00, bcd_p1[9:8]};
        digit_blank = (bcd_p1[9:8] == 2'd0);
      end
      default: digit_val = {1'b0, winner_p0};
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ref_cnt_p2 <= '0;
      sel_p2     <= 2'd0;
      seg        <= SEG_BLANK;
      an         <= 4'hF;
    end else if ((state == DISPLAY) && (state_nx == DISPLAY)) begin
      seg <= digit_blank ? SEG_BLANK : seg_code(digit_val);
      an  <= ~(4'b0001 << sel_p2);
      if (ref_cnt_p2 == CNT_LAST) begin
        ref_cnt_p2 <= '0;
        sel_p2     <= sel_p2 + 2'd1;
      end else begin
        ref_cnt_p2 <= ref_cnt_p2 + 1'b1;
      end
    end else begin
      ref_cnt_p2 <= '0;
      sel_p2     <= 2'd0;
      seg        <= SEG_BLANK;
      an         <= 4'hF;
    end
  end

endmodule
